// File: rtl/corr_frame_streamer_pkg.sv
// corr_streamer_pkg: shared definitions for the correlator frame streamer.
//   - serializer state enum
//   - header magic, words-per-frame count, frame word-select indices
//   - frame_width(): width of one stored FIFO entry for a given word width
// Build option: CORR_SEQ_HEADER_EN adds a header word and a 16-bit sequence
// number stored with each frame.
package corr_streamer_pkg;

  localparam logic [15:0] HDR_MAGIC = 16'hC0DE;

  // Number of product words carried per frame.
  localparam int unsigned DATA_WORDS = 4;

`ifdef CORR_SEQ_HEADER_EN
  localparam int unsigned FRAME_WORDS = 5;
  localparam int unsigned SEQ_BITS    = 16;
`else
  localparam int unsigned FRAME_WORDS = 4;
  localparam int unsigned SEQ_BITS    = 0;
`endif

  // Word positions inside a packed frame {aa, bb, ab_re, ab_im}.
  localparam int unsigned SEL_IM = 0;
  localparam int unsigned SEL_RE = 1;
  localparam int unsigned SEL_BB = 2;
  localparam int unsigned SEL_AA = 3;

  typedef enum logic [2:0] {
    IDLE,
`ifdef CORR_SEQ_HEADER_EN
    HDR,
`endif
    W_AA,
    W_BB,
    W_RE,
    W_IM
  } state_t;

  function automatic int unsigned frame_width(input int unsigned din_width);
    return DATA_WORDS * din_width + SEQ_BITS;
  endfunction

endpackage

// File: rtl/corr_frame_streamer_if.sv
// corr_frame_streamer_if: frame input and AXI-Stream style output bundle.
//   aa, bb        : unsigned accumulated auto-powers
//   ab_re, ab_im  : signed accumulated cross-correlation
//   din_valid     : one-cycle pulse, one complete frame on the product words
//   m_tdata/m_tvalid/m_tlast : serialized output stream
//   m_tready      : downstream ready
// Modport master is the streamer side, slave is the surrounding system.
interface corr_frame_streamer_if #(
  parameter int unsigned DIN_WIDTH = 32
);
  logic [DIN_WIDTH-1:0] aa;
  logic [DIN_WIDTH-1:0] bb;
  logic [DIN_WIDTH-1:0] ab_re;
  logic [DIN_WIDTH-1:0] ab_im;
  logic                 din_valid;
  logic [DIN_WIDTH-1:0] m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready;

  modport master (
    input  aa, bb, ab_re, ab_im, din_valid, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output aa, bb, ab_re, ab_im, din_valid, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/corr_frame_streamer_fifo.sv
// corr_frame_fifo: synchronous FIFO holding whole correlator frames.
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write request and entry; ignored when full unless popping
//   pop       : release the head entry; ignored when empty
//   head      : entry at the read pointer (combinational read)
//   head_next : entry after the head, used to start the next frame
//               in the same cycle the head is released
//   full, empty, level : occupancy status
// DEPTH must be a power of two and at least 2.
module corr_frame_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // A full FIFO still accepts a write when the head leaves in the same
  // cycle: the freed slot is the one the write pointer already points at.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rd_ptr_next = rd_ptr + AW'(1);
  assign head        = mem[rd_ptr];
  assign head_next   = mem[rd_ptr_next];

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr_next;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/corr_frame_streamer.sv
// corr_frame_streamer: buffers correlator frames and serializes each one
// onto a word stream as aa, bb, ab_re, ab_im (m_tlast on ab_im).
//   clk, rst   : clock, synchronous active-high reset
//   bus        : corr_frame_streamer_if.master (frame input + output stream)
//   drop_count : frames discarded because the FIFO was full (saturating)
//   fifo_level : frames stored, including the one being serialized
// Build option: CORR_SEQ_HEADER_EN prefixes every frame with the header word
// {16'hC0DE, seq[15:0]} (zero-extended), seq counting accepted frames.
// DIN_WIDTH >= 32 is required with the header; FIFO_DEPTH is a power of two,
// minimum 2.
module corr_frame_streamer
  import corr_streamer_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  corr_frame_streamer_if.master         bus,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned FRAME_W = frame_width(DIN_WIDTH);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  state_t               state;
  logic [FRAME_W-1:0]   wr_frame;
  logic [FRAME_W-1:0]   head;
  logic [FRAME_W-1:0]   head_next;
  logic [FRAME_W-1:0]   start_frame;
  logic [DIN_WIDTH-1:0] first_word;
  logic                 start_avail;
  logic                 full;
  logic                 empty;
  logic                 hs;
  logic                 pop;
  logic                 push_ok;
  logic                 drop;

  function automatic logic [DIN_WIDTH-1:0] word_of(input logic [FRAME_W-1:0] f,
                                                   input int unsigned sel);
    return f[sel*DIN_WIDTH +: DIN_WIDTH];
  endfunction

`ifdef CORR_SEQ_HEADER_EN
  localparam state_t FIRST_STATE = HDR;

  logic [15:0] seq;

  function automatic logic [DIN_WIDTH-1:0] hdr_of(input logic [FRAME_W-1:0] f);
    logic [DIN_WIDTH-1:0] h;
    h       = '0;
    h[31:0] = {HDR_MAGIC, f[DATA_WORDS*DIN_WIDTH +: SEQ_BITS]};
    return h;
  endfunction

  assign wr_frame   = {seq, bus.aa, bus.bb, bus.ab_re, bus.ab_im};
  assign first_word = hdr_of(start_frame);

  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '0;
    end else if (push_ok) begin
      seq <= seq + 16'd1;
    end
  end
`else
  localparam state_t FIRST_STATE = W_AA;

  assign wr_frame   = {bus.aa, bus.bb, bus.ab_re, bus.ab_im};
  assign first_word = word_of(start_frame, SEL_AA);
`endif

  assign hs      = bus.m_tvalid && bus.m_tready;
  assign pop     = (state == W_IM) && hs;
  assign push_ok = bus.din_valid && (!full || pop);
  assign drop    = bus.din_valid && full && !pop;

  corr_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.din_valid),
    .pop       (pop),
    .din       (wr_frame),
    .head      (head),
    .head_next (head_next),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Pick the frame whose first word is loaded into the output register.
  // The FIFO only reflects a push or pop after the edge, so the frame that
  // will be at the head next cycle is chosen here: the entry behind the
  // head when one is stored, otherwise the frame arriving right now. This
  // gives zero-bubble frame turnaround and the one-cycle input latency.
  always_comb begin
    start_avail = 1'b0;
    start_frame = wr_frame;
    if (state == IDLE) begin
      start_avail = !empty || push_ok;
      start_frame = empty ? wr_frame : head;
    end else if (state == W_IM) begin
      start_avail = (fifo_level > LEVEL_W'(1)) || push_ok;
      start_frame = (fifo_level > LEVEL_W'(1)) ? head_next : wr_frame;
    end
  end

  // Output register holds the word being offered; the head entry stays in
  // the FIFO until the last word handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.m_tvalid <= 1'b0;
      bus.m_tlast  <= 1'b0;
      bus.m_tdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_avail) begin
            state        <= FIRST_STATE;
            bus.m_tvalid <= 1'b1;
            bus.m_tdata  <= first_word;
          end
        end
`ifdef CORR_SEQ_HEADER_EN
        HDR: begin
          if (hs) begin
            state       <= W_AA;
            bus.m_tdata <= word_of(head, SEL_AA);
          end
        end
`endif
        W_AA: begin
          if (hs) begin
            state       <= W_BB;
            bus.m_tdata <= word_of(head, SEL_BB);
          end
        end
        W_BB: begin
          if (hs) begin
            state       <= W_RE;
            bus.m_tdata <= word_of(head, SEL_RE);
          end
        end
        W_RE: begin
          if (hs) begin
            state       <= W_IM;
            bus.m_tdata <= word_of(head, SEL_IM);
            bus.m_tlast <= 1'b1;
          end
        end
        W_IM: begin
          if (hs) begin
            bus.m_tlast <= 1'b0;
            if (start_avail) begin
              state       <= FIRST_STATE;
              bus.m_tdata <= first_word;
            end else begin
              state        <= IDLE;
              bus.m_tvalid <= 1'b0;
              bus.m_tdata  <= '0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          bus.m_tvalid <= 1'b0;
          bus.m_tlast  <= 1'b0;
          bus.m_tdata  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_corr_frame_streamer.sv
// Self-checking bench for corr_frame_streamer (DIN_WIDTH=32, FIFO_DEPTH=8).
// Expected words are queued when a frame is driven and compared as the
// stream hands them off; directed steps cover reset, latency, throughput,
// backpressure, overflow, full push+pop and mid-frame reset.
module tb_corr_frame_streamer;
  localparam int W     = 32;
  localparam int DEPTH = 8;
`ifdef CORR_SEQ_HEADER_EN
  localparam int FW = 5;
`else
  localparam int FW = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] drop_count;
  logic [3:0]  fifo_level;

  always #5 clk = ~clk;

  corr_frame_streamer_if #(.DIN_WIDTH(W)) bus ();

  corr_frame_streamer #(
    .DIN_WIDTH  (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  word_t       exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] tseq     = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic [31:0] i,
                            input bit accept);
    bus.aa        = a;
    bus.bb        = b;
    bus.ab_re     = r;
    bus.ab_im     = i;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    if (accept) begin
`ifdef CORR_SEQ_HEADER_EN
      exp_q.push_back('{d: {16'hC0DE, tseq}, l: 1'b0});
      tseq++;
`endif
      exp_q.push_back('{d: a, l: 1'b0});
      exp_q.push_back('{d: b, l: 1'b0});
      exp_q.push_back('{d: r, l: 1'b0});
      exp_q.push_back('{d: i, l: 1'b1});
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Stream monitor: scoreboard compare on handshake, hold-stable checks
  // while stalled, and no valid gap inside a frame.
  logic        stall_q = 1'b0;
  logic        mid_q   = 1'b0;
  logic [31:0] data_q  = '0;
  logic        last_q  = 1'b0;

  always @(negedge clk) begin
    word_t w;
    if (rst !== 1'b0) begin
      stall_q = 1'b0;
      mid_q   = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", bus.m_tvalid, 1);
        check("hold_data", bus.m_tdata, data_q);
        check("hold_last", bus.m_tlast, last_q);
      end
      if (mid_q) begin
        check("valid_mid_frame", bus.m_tvalid, 1);
      end
      mid_q = 1'b0;
      if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_word observed=0x%0h expected=none", {bus.m_tlast, bus.m_tdata});
        end
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("word", {bus.m_tlast, bus.m_tdata}, {w.l, w.d});
        end
        mid_q = (bus.m_tlast === 1'b0);
      end
      stall_q = (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b0);
      data_q  = bus.m_tdata;
      last_q  = bus.m_tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset, with a frame offered during reset that must be ignored.
    rst           = 1'b1;
    bus.m_tready  = 1'b1;
    bus.aa        = 32'h11;
    bus.bb        = 32'h22;
    bus.ab_re     = 32'h33;
    bus.ab_im     = 32'h44;
    bus.din_valid = 1'b1;
    repeat (3) step();
    bus.din_valid = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    check("rst_tvalid", bus.m_tvalid, 0);
    check("rst_tlast", bus.m_tlast, 0);
    check("rst_tdata", bus.m_tdata, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_count, 0);

    // Single frame and first-word latency.
    step();
    push_frame(32'd1, 32'd2, 32'hFFFF_FFFD, 32'd4, 1'b1);
    @(negedge clk);
    check("latency_valid", bus.m_tvalid, 1);
`ifdef CORR_SEQ_HEADER_EN
    check("latency_data", bus.m_tdata, 32'hC0DE_0000);
`else
    check("latency_data", bus.m_tdata, 32'd1);
`endif
    wait_drain(20, "single_drain");
    step();
    @(negedge clk);
    check("single_level", fifo_level, 0);

    // Three back-to-back frames with ready held high: no bubbles.
    step();
    push_frame(32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1);
    push_frame(32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b1);
    push_frame(32'hC0, 32'hC1, 32'hC2, 32'hC3, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("throughput_cycles", n, 3 * FW - 2);
    step();
    @(negedge clk);
    check("throughput_level", fifo_level, 0);

    // Backpressure: ready toggling every cycle.
    step();
    bus.m_tready = 1'b0;
    push_frame(32'h1234_5678, 32'h9ABC_DEF0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      bus.m_tready = ~bus.m_tready;
      step();
    end
    check("bp_drain", exp_q.size(), 0);
    bus.m_tready = 1'b1;
    step();
    @(negedge clk);
    check("bp_level", fifo_level, 0);

    // Overflow: ten frames into eight slots with no pops.
    step();
    bus.m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_frame(32'h100 + i, 32'h200 + i, 32'h300 + i, 32'h400 + i, i < DEPTH);
    end
    @(negedge clk);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_drop", drop_count, 2);
    step();
    bus.m_tready = 1'b1;
    wait_drain(200, "ovf_drain");
    step();
    @(negedge clk);
    check("ovf_level_empty", fifo_level, 0);

    // Full FIFO, push lands on the last-word handshake of the head frame.
    step();
    bus.m_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_frame(32'h500 + i, 32'h600 + i, 32'h700 + i, 32'h800 + i, 1'b1);
    end
    bus.m_tready = 1'b1;
    repeat (FW - 1) step();
    push_frame(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004, 1'b1);
    @(negedge clk);
    check("fullpp_level", fifo_level, DEPTH);
    check("fullpp_drop", drop_count, 2);
    wait_drain(200, "fullpp_drain");
    step();
    @(negedge clk);
    check("fullpp_level_empty", fifo_level, 0);
    check("fullpp_drop_end", drop_count, 2);

    // Reset after the second word of a frame is accepted.
    step();
    bus.m_tready = 1'b1;
    push_frame(32'hE0, 32'hE1, 32'hE2, 32'hE3, 1'b1);
    push_frame(32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b1);
    step();
    bus.m_tready  = 1'b0;
    rst           = 1'b1;
    bus.aa        = 32'h99;
    bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", bus.m_tvalid, 0);
    check("midrst_tlast", bus.m_tlast, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_drop", drop_count, 0);
    step();
    rst = 1'b0;
    exp_q.delete();
    tseq = '0;
    bus.m_tready = 1'b1;
    repeat (4) step();
    check("midrst_idle_valid", bus.m_tvalid, 0);
    push_frame(32'h0BAD_F00D, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_drain(20, "midrst_new_frame");
    step();
    @(negedge clk);
    check("midrst_end_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/corr_frame_streamer.md
CORR_FRAME_STREAMER -- requirements
Module: corr_frame_streamer

Interface
REQ-001 Parameter DIN_WIDTH, default 32, width of each correlator product word (aa, bb, ab_re, ab_im) and of m_tdata.
REQ-002 Parameter FIFO_DEPTH, default 8, number of whole correlator frames buffered; power of two, minimum 2.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 aa, bb  input  DIN_WIDTH  unsigned accumulated auto-powers.
REQ-006 ab_re, ab_im  input  DIN_WIDTH  signed accumulated cross-correlation.
REQ-007 din_valid  input  1  single-cycle pulse marking one complete frame on aa/bb/ab_re/ab_im.
REQ-008 m_tdata  output  DIN_WIDTH  serialized frame word.
REQ-009 m_tvalid, m_tlast  output  1  stream valid; last word of a frame.
REQ-010 m_tready  input  1  downstream ready.
REQ-011 drop_count  output  32  frames dropped because the FIFO was full.
REQ-012 fifo_level  output  $clog2(FIFO_DEPTH)+1  frames currently stored, including the frame being serialized.

Function
REQ-013 On din_valid with FIFO not full, the block SHALL store {aa, bb, ab_re, ab_im} as one FIFO entry.
REQ-014 On din_valid with FIFO full and no pop in the same cycle, the block SHALL discard the frame and increment drop_count, saturating at 0xFFFFFFFF.
REQ-015 On din_valid with FIFO full and a pop in the same cycle, the block SHALL accept the new frame and leave drop_count unchanged.
REQ-016 The serializer SHALL emit words in the order aa, bb, ab_re, ab_im, with m_tlast high only on ab_im.
REQ-017 The serializer FSM SHALL have the states IDLE, HDR (macro builds only), W_AA, W_BB, W_RE and W_IM.
REQ-018 IDLE SHALL go to the first word state when fifo_level is nonzero; each word state SHALL advance only on m_tvalid and m_tready both high.
REQ-019 W_IM SHALL, on handshake, pop the entry and go directly to the first word state if another frame is stored, otherwise to IDLE, with no bubble cycle.
REQ-020 While m_tvalid is high and m_tready is low, m_tdata and m_tlast SHALL hold stable; m_tvalid SHALL NOT deassert before the handshake.
REQ-021 Latency: with the FIFO empty and m_tready high, m_tvalid SHALL rise in the cycle after din_valid, with the first word of that frame.
REQ-022 Throughput: with m_tready held high, the block SHALL deliver 4 words per frame (5 with the macro) back-to-back.
REQ-023 An entry SHALL be popped only on the handshake of its last word; a partially sent frame is never lost to overflow.
REQ-024 fifo_level SHALL update in the cycle after a push or pop, and SHALL be unchanged when a push and a pop occur together.

Reset
REQ-025 In the cycle after rst is high, the block SHALL drive m_tvalid=0, m_tlast=0, m_tdata=0, fifo_level=0 and drop_count=0, with the FSM in IDLE and pointers cleared.
REQ-026 A reset mid-frame SHALL abandon that frame without a terminating m_tlast, and no stored frame SHALL be output after reset.
REQ-027 A din_valid that coincides with rst SHALL be ignored.

Configuration
REQ-028 Macro CORR_SEQ_HEADER_EN defined: each frame SHALL be preceded by one header word (state HDR) equal to {16'hC0DE, seq[15:0]}, zero-extended to DIN_WIDTH; DIN_WIDTH >= 32 is required.
REQ-029 seq SHALL be the count of accepted frames, starting at 0 after reset and wrapping 0xFFFF to 0; dropped frames SHALL NOT advance it; seq is stored with its frame.
REQ-030 Macro not defined: no HDR state, no seq storage, 4-word frames.

Structure
REQ-031 Package corr_streamer_pkg SHALL hold the FSM state enum, the HDR_MAGIC constant (16'hC0DE), the FRAME_WORDS constant, and the word-select mux indices.
REQ-032 Frame storage SHALL be one sub-module, corr_frame_fifo: a synchronous FIFO FIFO_DEPTH entries deep and 4*DIN_WIDTH bits wide (plus 16 bits with the macro), with full, empty and level outputs.

Verification
REQ-033 Single frame: aa=1, bb=2, ab_re=-3, ab_im=4, m_tready=1 -> words 1, 2, 0xFFFFFFFD, 4 on consecutive cycles, tlast on 4, fifo_level back to 0.
REQ-034 Backpressure: m_tready toggled 1/0 every cycle during a frame -> each word held stable until accepted, 4 words in order, tvalid never drops mid-frame.
REQ-035 Overflow: m_tready=0 and 10 frames pushed with FIFO_DEPTH=8 -> fifo_level=8, drop_count=2, then draining yields the first 8 frames in order.
REQ-036 Full with pop and push together: FIFO full, push on the cycle of the last word's handshake -> new frame accepted, drop_count unchanged, fifo_level stays 8.
REQ-037 Reset mid-frame: rst after the second word is accepted -> next cycle tvalid=0, fifo_level=0, drop_count=0; a new frame afterward is output complete.
REQ-038 Macro on: 3 frames pushed -> headers 0xC0DE0000, 0xC0DE0001, 0xC0DE0002, each followed by 4 data words; a dropped frame leaves a seq gap of none.
